// File: rtl/mmu_hs_pkg.sv
// Shared definitions for the MMU handshake queues: launcher states,
// default queue geometry and pointer/count width helpers.
package mmu_hs_pkg;

    typedef enum logic {
        LNCH_IDLE = 1'b0,
        LNCH_WAIT = 1'b1
    } lnch_state_e;

    localparam int MMU_Q_DEPTH = 4;
    localparam int MMU_Q_WIDTH = 32;

    // Width of a pointer that indexes 0..depth-1 (never narrower than one bit).
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Width of an occupancy counter that must hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mmu_pulse_delay.sv
// Delays a single-cycle pulse by DELAY clock cycles using a shift register.
// Reset clears every stage, so a pulse in flight is cancelled.
module mmu_pulse_delay #(
    parameter int DELAY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_i,
    output logic pulse_o
);

    logic [DELAY-1:0] stage_q;

    // Shift the pulse one stage per clock; stage 0 captures the input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= pulse_i;
            for (int i = 1; i < DELAY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign pulse_o = stage_q[DELAY-1];

endmodule

// File: rtl/sfifo_n_mmu.sv
// DEPTH-entry circular-buffer FIFO between MMU request stages. Tokens enter
// on a drive pulse and leave one at a time on o_driveNext, DRIVE_DELAY
// cycles after the launcher commits to sending the head entry.
module sfifo_n_mmu
    import mmu_hs_pkg::*;
#(
    parameter int DEPTH       = MMU_Q_DEPTH,
    parameter int WIDTH       = MMU_Q_WIDTH,
    parameter int DRIVE_DELAY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_drive,
    input  logic [WIDTH-1:0]             i_data,
    output logic                         o_free,
    output logic                         o_fire,
    input  logic                         i_freeNext,
    output logic                         o_driveNext,
    output logic [WIDTH-1:0]             o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_overflow
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             overflow_q;
    logic             fire_q;
    logic [WIDTH-1:0] data_q;
    lnch_state_e      state_q;
    lnch_state_e      state_d;

    logic free;
    logic push_acc;
    logic launch;
    logic delay_fire;

    // Space is judged from the registered count, so a same-cycle launch
    // does not make room for a push arriving while full.
    assign free     = (count_q != CNT_FULL);
    assign push_acc = i_drive & free;

    // Launcher: commit to a launch from IDLE, then wait for the delayed pulse.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            LNCH_IDLE: begin
                if ((count_q != '0) && i_freeNext) begin
                    launch  = 1'b1;
                    state_d = LNCH_WAIT;
                end
            end
            LNCH_WAIT: begin
                if (delay_fire) begin
                    state_d = LNCH_IDLE;
                end
            end
            default: state_d = LNCH_IDLE;
        endcase
    end

    // Occupancy: a push and a launch in the same cycle cancel out.
    always_comb begin
        count_d = count_q;
        case ({push_acc, launch})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: launcher, pointers, count, flags and the output payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LNCH_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            fire_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            fire_q  <= push_acc;
            if (i_drive && !free) begin
                overflow_q <= 1'b1;
            end
            if (push_acc) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (launch) begin
                data_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    mmu_pulse_delay #(
        .DELAY (DRIVE_DELAY)
    ) u_drive_delay (
        .clk     (clk),
        .rst     (rst),
        .pulse_i (launch),
        .pulse_o (delay_fire)
    );

    assign o_free      = free;
    assign o_fire      = fire_q;
    assign o_driveNext = delay_fire;
    assign o_data      = data_q;
    assign o_count     = count_q;
    assign o_overflow  = overflow_q;

endmodule
